// File: rtl/mram_controller.sv
// Single-port MRAM controller: one host request at a time, fixed-length strobe windows.
// Optional address-range check compiled in by defining MRAM_CTRL_ADDR_CHECK_EN.
module mram_controller #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int WR_WAIT    = 1,
  parameter int RD_WAIT    = 2,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  e_chipEnable_n,
  output logic                  g_outputEnable_n,
  output logic                  w_writeEnable_n,
  output logic                  lb_lowerByteEnable_n,
  output logic                  ub_upperByteEnable_n,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] dqi_datainput,
  input  logic [DATA_WIDTH-1:0] dqo_dataoutput
);

  if (WR_WAIT < 1 || WR_WAIT > 15 || RD_WAIT < 1 || RD_WAIT > 15 || MEM_DEPTH < 1) begin : g_bad_param
    $error("mram_controller: wait/depth parameter out of range");
  end

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE, and every req_* input is ignored otherwise.
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [1:0]      be_q;
  logic            bad_addr;
  logic [DATA_WIDTH-1:0] lane_mask;

`ifdef MRAM_CTRL_ADDR_CHECK_EN
  assign bad_addr = (req_addr >= ADDR_WIDTH'(MEM_DEPTH));
`else
  assign bad_addr = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  // Disabled lanes read as zero so a floating bus never reaches the host.
  assign lane_mask = {{(DATA_WIDTH/2){be_q[1]}}, {(DATA_WIDTH-DATA_WIDTH/2){be_q[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      be_q                 <= '0;
      address              <= '0;
      dqi_datainput        <= '0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
      rsp_err              <= 1'b0;
      e_chipEnable_n       <= 1'b1;
      g_outputEnable_n     <= 1'b1;
      w_writeEnable_n      <= 1'b1;
      lb_lowerByteEnable_n <= 1'b1;
      ub_upperByteEnable_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_be == 2'b00 || bad_addr) begin
              // Nothing reaches the MRAM; answer in the very next cycle.
              rsp_valid <= 1'b1;
              rsp_err   <= bad_addr;
            end else begin
              address              <= req_addr;
              be_q                 <= req_be;
              e_chipEnable_n       <= 1'b0;
              lb_lowerByteEnable_n <= ~req_be[0];
              ub_upperByteEnable_n <= ~req_be[1];
              if (req_write) begin
                dqi_datainput   <= req_wdata;
                w_writeEnable_n <= 1'b0;
                cnt             <= 4'(WR_WAIT - 1);
                state           <= WRITE;
              end else begin
                g_outputEnable_n <= 1'b0;
                cnt              <= 4'(RD_WAIT - 1);
                state            <= READ;
              end
            end
          end
        end
        WRITE, READ: begin
          if (cnt == 4'd0) begin
            if (state == READ) rsp_rdata <= dqo_dataoutput & lane_mask;
            state                <= IDLE;
            rsp_valid            <= 1'b1;
            e_chipEnable_n       <= 1'b1;
            g_outputEnable_n     <= 1'b1;
            w_writeEnable_n      <= 1'b1;
            lb_lowerByteEnable_n <= 1'b1;
            ub_upperByteEnable_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mram_controller.sv
// Bench for mram_controller: directed vector table, reset-abort sequence and
// randomized requests checked against a word-level memory reference model.
module tb_mram_controller;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int WRW = 1;
  localparam int RDW = 2;
  localparam int MD  = 16;
`ifdef MRAM_CTRL_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    be;
    int            lat;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          e, g, w, lb, ub;
  logic [AW-1:0] address;
  logic [DW-1:0] dqi;
  wire  [DW-1:0] dqo;

  logic [DW-1:0] dev_mem [0:31];
  bit            dev_cleared = 1'b0;
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] last_rd;
  int            checks = 0;
  int            errors = 0;
  int            overlap = 0;

  mram_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_WAIT(WRW), .RD_WAIT(RDW), .MEM_DEPTH(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .e_chipEnable_n(e), .g_outputEnable_n(g), .w_writeEnable_n(w),
    .lb_lowerByteEnable_n(lb), .ub_upperByteEnable_n(ub),
    .address(address), .dqi_datainput(dqi), .dqo_dataoutput(dqo)
  );

  always #5 clk = ~clk;

  // MRAM device: drives only enabled lanes, leaves the rest floating.
  assign dqo[15:8] = (!e && !g && !ub) ? dev_mem[address[4:0]][15:8] : 8'hzz;
  assign dqo[7:0]  = (!e && !g && !lb) ? dev_mem[address[4:0]][7:0]  : 8'hzz;

  always @(posedge clk) begin
    if (!dev_cleared) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= '0;
      dev_cleared <= 1'b1;
    end else if (!e && !w) begin
      if (!lb) dev_mem[address[4:0]][7:0]  <= dqi[7:0];
      if (!ub) dev_mem[address[4:0]][15:8] <= dqi[15:8];
    end
  end

  always @(negedge clk) if (!w && !g) overlap++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word memory with per-lane merge; latency from the strobe-window rules.
  task automatic model(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [1:0] be, output int lat, output logic err,
                       output logic [DW-1:0] rd);
    bit            bad;
    logic [DW-1:0] mask;
    bad  = CHK_EN && (addr >= AW'(MD));
    mask = {{8{be[1]}}, {8{be[0]}}};
    err  = bad;
    if (bad || be == 2'b00) lat = 1;
    else if (wr) begin
      lat = WRW + 1;
      ref_mem[addr[4:0]] = (ref_mem[addr[4:0]] & ~mask) | (wd & mask);
    end else begin
      lat = RDW + 1;
      last_rd = ref_mem[addr[4:0]] & mask;
    end
    rd = last_rd;
  endtask

  // Called in the low clock phase; returns at the falling edge of the response cycle.
  task automatic check_req(input string name, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [1:0] be,
                           input int exp_lat, input logic exp_err, input logic [DW-1:0] exp_rd);
    int lat;
    bit busy_bad;
    lat = 0;
    busy_bad = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    // Garbage with valid held high must be ignored while busy.
    req_write = 1'($urandom_range(0, 1)); req_addr = AW'($urandom);
    req_wdata = DW'($urandom); req_be = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      lat = k;
      if (rsp_valid === 1'b1) break;
      if (req_ready !== 1'b0 || e !== 1'b0 || w !== !wr || g !== wr ||
          lb !== ~be[0] || ub !== ~be[1] || address !== addr || (wr && dqi !== wd))
        busy_bad = 1'b1;
    end
    req_valid = 1'b0;
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({name, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
    chk({name, "_busy_strobes_bad"}, {31'd0, busy_bad}, 32'd0);
    chk({name, "_idle_ctl"}, {27'd0, e, g, w, lb, ub}, 32'h1f);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t          vt [12];
    int            ml;
    logic          me;
    logic [DW-1:0] mr;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    last_rd = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {27'd0, e, g, w, lb, ub}, 32'h1f);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_address", {12'd0, address}, 32'd0);
    chk("rst_dqi", {16'd0, dqi}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vt[0]  = '{1'b1, 20'd3,  16'hA5C3, 2'b11, 2, 1'b0, 16'h0000};
    vt[1]  = '{1'b0, 20'd3,  16'h0000, 2'b11, 3, 1'b0, 16'hA5C3};
    vt[2]  = '{1'b1, 20'd5,  16'h1234, 2'b11, 2, 1'b0, 16'hA5C3};
    vt[3]  = '{1'b1, 20'd5,  16'hFF00, 2'b01, 2, 1'b0, 16'hA5C3};
    vt[4]  = '{1'b0, 20'd5,  16'h0000, 2'b11, 3, 1'b0, 16'h1200};
    vt[5]  = '{1'b0, 20'd5,  16'h0000, 2'b10, 3, 1'b0, 16'h1200};
    vt[6]  = '{1'b0, 20'd3,  16'h0000, 2'b01, 3, 1'b0, 16'h00C3};
    vt[7]  = '{1'b1, 20'd3,  16'hFFFF, 2'b00, 1, 1'b0, 16'h00C3};
    vt[8]  = '{1'b0, 20'd3,  16'h0000, 2'b11, 3, 1'b0, 16'hA5C3};
`ifdef MRAM_CTRL_ADDR_CHECK_EN
    vt[9]  = '{1'b1, 20'd16, 16'hBEEF, 2'b11, 1, 1'b1, 16'hA5C3};
    vt[10] = '{1'b0, 20'd16, 16'h0000, 2'b11, 1, 1'b1, 16'hA5C3};
    vt[11] = '{1'b0, 20'd0,  16'h0000, 2'b00, 1, 1'b0, 16'hA5C3};
`else
    vt[9]  = '{1'b1, 20'd16, 16'hBEEF, 2'b11, 2, 1'b0, 16'hA5C3};
    vt[10] = '{1'b0, 20'd16, 16'h0000, 2'b11, 3, 1'b0, 16'hBEEF};
    vt[11] = '{1'b0, 20'd0,  16'h0000, 2'b00, 1, 1'b0, 16'hBEEF};
`endif
    // First vector is accepted on the first rising edge after reset release.
    for (int i = 0; i < 12; i++) begin
      model(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, ml, me, mr);
      check_req($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be,
                vt[i].lat, vt[i].err, vt[i].rdata);
    end

    // Reset during the second READ cycle aborts the transfer.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'd3; req_be = 2'b11;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_mid_read", {29'd0, e, g, w}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {27'd0, e, g, w, lb, ub}, 32'h1f);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    model(1'b0, 20'd3, 16'h0, 2'b11, ml, me, mr);
    check_req("post_rst", 1'b0, 20'd3, 16'h0, 2'b11, ml, me, mr);

    for (int n = 0; n < 80; n++) begin
      bit            rw;
      logic [AW-1:0] ra;
      logic [DW-1:0] rdv;
      logic [1:0]    rb;
      rw  = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 19));
      rdv = DW'($urandom);
      rb  = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(rw, ra, rdv, rb, ml, me, mr);
      check_req($sformatf("rnd%0d", n), rw, ra, rdv, rb, ml, me, mr);
    end

    repeat (2) @(negedge clk);
    chk("w_g_overlap", overlap, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mram_controller.md
MRAM_CONTROLLER -- requirements
Module: mram_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, MRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, MRAM word width (two byte lanes).
REQ-003 SHALL have parameter WR_WAIT, default 1, cycles the write strobes stay asserted (range 1-15).
REQ-004 SHALL have parameter RD_WAIT, default 2, cycles the read strobes stay asserted before capture (range 1-15).
REQ-005 SHALL have parameter MEM_DEPTH, default 16, number of implemented MRAM words (used only under REQ-025).
REQ-006 SHALL have ports (name  direction  width  meaning), one clock, reset asynchronous active-low:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  2  active-high byte enables, bit0 = [7:0], bit1 = [15:8]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads
- rsp_err  out  1  address-range error, valid with rsp_valid
- e_chipEnable_n, g_outputEnable_n, w_writeEnable_n  out  1 each  MRAM strobes, active-low
- lb_lowerByteEnable_n, ub_upperByteEnable_n  out  1 each  MRAM byte enables, active-low
- address  out  ADDR_WIDTH  MRAM address
- dqi_datainput  out  DATA_WIDTH  MRAM write data
- dqo_dataoutput  in  DATA_WIDTH  MRAM read data (undriven lanes may be z)

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, READ; req_ready = 1 only in IDLE.
REQ-008 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, registering write, addr, wdata and be.
REQ-009 SHALL, for an accepted write with req_be != 0, go to WRITE for exactly WR_WAIT cycles with e=0, w=0, g=1, lb_n = ~be[0], ub_n = ~be[1], address and dqi held at the registered values.
REQ-010 SHALL, for an accepted read with req_be != 0, go to READ for exactly RD_WAIT cycles with e=0, g=0, w=1, same byte-enable mapping.
REQ-011 SHALL sample dqo_dataoutput on the last READ edge into rsp_rdata, forcing disabled byte lanes to 0 (no x/z propagation).
REQ-012 SHALL return to IDLE after the last WRITE/READ cycle and assert rsp_valid for exactly the first IDLE cycle; latency from accept edge to rsp_valid = WR_WAIT+1 (write) or RD_WAIT+1 (read) cycles.
REQ-013 SHALL hold rsp_rdata stable until the next read completion; rsp_rdata is don't-care for writes but SHALL NOT change on write completion.
REQ-014 SHALL permit back-to-back requests: a request accepted in the rsp_valid cycle starts immediately, so there is no idle gap beyond that cycle.
REQ-015 SHALL treat req_be = 2'b00 as a no-op: no strobe asserted, rsp_valid exactly 1 cycle after accept, rsp_err = 0.
REQ-016 SHALL drive all five active-low MRAM controls to 1 in IDLE; address and dqi retain their last values.
REQ-017 SHALL never assert w_writeEnable_n = 0 and g_outputEnable_n = 0 in the same cycle.
REQ-018 SHALL ignore req_valid and all req_* inputs while req_ready = 0.

Reset
REQ-019 SHALL, while rst_n = 0 and independent of clk, force state IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, address = 0, dqi = 0, and all MRAM _n outputs = 1.
REQ-020 SHALL, on reset mid-WRITE/READ, abort the transaction with no response pulse, and de-assert strobes immediately.
REQ-021 SHALL accept a request on the first rising edge after rst_n rises.

Configuration
REQ-022 SHALL compile the address-range check only when macro MRAM_CTRL_ADDR_CHECK_EN is defined.
REQ-023 SHALL, with MRAM_CTRL_ADDR_CHECK_EN defined, complete an accepted request with req_addr >= MEM_DEPTH like a no-op (REQ-015) but with rsp_err = 1 and rsp_rdata unchanged.
REQ-024 SHALL, without the macro, tie rsp_err to 0 and issue every address to the MRAM.
REQ-025 SHALL apply MEM_DEPTH only when the macro is defined.

Verification
REQ-026 Write addr 3, data 16'hA5C3, be 2'b11, then read addr 3 -> write strobes for 1 cycle, rsp_valid 2 cycles after accept; read rsp_valid 3 cycles after accept with rsp_rdata 16'hA5C3.
REQ-027 Write 16'h1234 be 2'b11 to addr 5, then 16'hFF00 be 2'b01 -> ub_n = 1, lb_n = 0; read returns 16'h1200.
REQ-028 Read addr 5 with be 2'b10 -> lb_n = 1, rsp_rdata 16'h1200 with the lower lane 0 despite z on the bus.
REQ-029 Request be 2'b00 -> no strobe asserted, rsp_valid 1 cycle after accept, rsp_err = 0.
REQ-030 Pull rst_n low during the 2nd READ cycle -> strobes go to 1 asynchronously, no rsp_valid, req_ready = 1; a new request after release completes normally.
REQ-031 With MRAM_CTRL_ADDR_CHECK_EN, write addr 16 -> e_chipEnable_n stays 1, rsp_err = 1 with rsp_valid; without the macro -> write issued, rsp_err = 0.
